// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
// Optional perf_fetched/perf_bubbles counters under `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  OP,
  output logic [5:0]  func,
  output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } sel_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  sel_t        sel;
  logic [31:0] pc_next_seq;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign imem_addr     = pc;
  assign OP            = if_id_instr[31:26];
  assign func          = if_id_instr[5:0];
  assign pc_next_seq   = pc + 32'd4;
  assign branch_offset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
  assign branch_target = if_id_pc_plus4 + branch_offset;
  assign jump_target   = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};

  // A bubble in ID carries no real control flow, so it can never redirect.
  always_comb begin
    sel = SEL_SEQ;
    if (stall)
      sel = SEL_HOLD;
    else if (id_jump && if_id_valid)
      sel = SEL_JUMP;
    else if (id_branch_taken && if_id_valid)
      sel = SEL_BRANCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC_ALIGNED;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_valid    <= 1'b0;
    end else begin
      case (sel)
        SEL_JUMP: begin
          pc          <= jump_target;
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
        end
        SEL_BRANCH: begin
          pc          <= branch_target;
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
        end
        SEL_SEQ: begin
          pc             <= pc_next_seq;
          if_id_instr    <= imem_rdata;
          if_id_pc_plus4 <= pc_next_seq;
          if_id_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0000_0000;
      perf_bubbles <= 32'h0000_0000;
    end else begin
      if (sel == SEL_SEQ)
        perf_fetched <= perf_fetched + 32'd1;
      if (sel == SEL_JUMP || sel == SEL_BRANCH)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        id_branch_taken = 1'b0;
  logic        id_jump = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  OP;
  logic [5:0]  func;
  logic [31:0] pc;

  logic        stall2 = 1'b0;
  logic        branch2 = 1'b0;
  logic        jump2 = 1'b0;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] if_id_instr2;
  logic [31:0] if_id_pc_plus42;
  logic        if_id_valid2;
  logic [5:0]  OP2;
  logic [5:0]  func2;
  logic [31:0] pc2;

  logic [31:0] mem  [0:31];
  logic [31:0] mem2 [0:31];
  logic [4:0]  idx;
  logic [4:0]  idx2;

  int n_checks = 0;
  int n_fail = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  always #5 clk = ~clk;

  assign idx         = 5'((imem_addr >> 2) & 32'h1F);
  assign idx2        = 5'((imem_addr2 >> 2) & 32'h1F);
  assign imem_rdata  = mem[idx];
  assign imem_rdata2 = mem2[idx2];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .OP(OP), .func(func), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_stage #(.RESET_PC(32'h4000_000C)) dut_hi (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .stall(stall2), .id_branch_taken(branch2), .id_jump(jump2),
    .if_id_instr(if_id_instr2), .if_id_pc_plus4(if_id_pc_plus42),
    .if_id_valid(if_id_valid2), .OP(OP2), .func(func2), .pc(pc2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pp4, input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".instr"}, if_id_instr, e_instr);
    chk({tag, ".pc_plus4"}, if_id_pc_plus4, e_pp4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'h0000_0000;
      mem2[i] = 32'h0000_0000;
    end
    mem[0]  = 32'h8C01_0004;
    mem[1]  = 32'h0022_1820;
    mem[2]  = 32'h2001_0008;
    mem[3]  = 32'h0800_0005;
    mem[4]  = 32'h1422_FFFD;
    mem[5]  = 32'h2003_0005;
    mem[6]  = 32'h1422_FFF8;
    mem[31] = 32'h2000_7777;
    mem2[3] = 32'h0800_0040;

    step();
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.imem_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    step();
    chk_if("fetch0", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    chk("fetch0.OP", {26'd0, OP}, 32'h23);
    step();
    chk_if("fetch4", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    chk("fetch4.OP", {26'd0, OP}, 32'h0);
    chk("fetch4.func", {26'd0, func}, 32'h20);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_if("release", 32'hC, 32'h2001_0008, 32'hC, 1'b1);
    step();
    chk_if("fetchC", 32'h10, 32'h0800_0005, 32'h10, 1'b1);
    step();
    chk_if("fetch_bne", 32'h14, 32'h1422_FFFD, 32'h14, 1'b1);

    id_branch_taken = 1'b1;
    step();
    chk_if("bne_taken", 32'h8, 32'h0, 32'h14, 1'b0);
    step();
    chk_if("bubble_no_redirect", 32'hC, 32'h2001_0008, 32'hC, 1'b1);
    id_branch_taken = 1'b0;
    step();
    chk_if("refetch_j", 32'h10, 32'h0800_0005, 32'h10, 1'b1);

    stall = 1'b1;
    id_jump = 1'b1;
    step();
    chk_if("stall_jump", 32'h10, 32'h0800_0005, 32'h10, 1'b1);
    stall = 1'b0;
    id_branch_taken = 1'b1;
    step();
    chk_if("jump_wins", 32'h14, 32'h0, 32'h10, 1'b0);
    id_jump = 1'b0;
    id_branch_taken = 1'b0;
    step();
    chk_if("after_jump", 32'h18, 32'h2003_0005, 32'h18, 1'b1);
    step();
    chk_if("fetch18", 32'h1C, 32'h1422_FFF8, 32'h1C, 1'b1);

    id_branch_taken = 1'b1;
    step();
    chk_if("bne_back", 32'hFFFF_FFFC, 32'h0, 32'h1C, 1'b0);
    id_branch_taken = 1'b0;
    step();
    chk_if("pc_wrap", 32'h0, 32'h2000_7777, 32'h0, 1'b1);
    step();
    chk_if("post_wrap", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);

    id_jump = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_if("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_reset", perf_fetched, 32'h0);
    chk("perf_bubbles_reset", perf_bubbles, 32'h0);
`endif
    step();
    chk_if("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("hi_reset.pc", pc2, 32'h4000_000C);
    rst_n = 1'b1;
    id_jump = 1'b0;
    step();
    chk_if("restart", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    chk("hi_fetch.instr", if_id_instr2, 32'h0800_0040);
    chk("hi_fetch.pc_plus4", if_id_pc_plus42, 32'h4000_0010);

    jump2 = 1'b1;
    step();
    chk("hi_jump.pc", pc2, 32'h4000_0100);
    chk("hi_jump.valid", {31'd0, if_id_valid2}, 32'h0);
    chk("hi_jump.instr", if_id_instr2, 32'h0);
    jump2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the control unit.
- Owns the PC, drives the instruction-memory address and latches the fetched word into IF/ID.
- Presents OP/func slices to the control unit.
- Applies load-use stalls and branch/jump redirects resolved in ID, inserting a bubble on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0) injected into IF/ID on flush/reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  byte address to instruction memory (= PC).
- imem_rdata  input  32  instruction word; combinational read of imem_addr, valid same cycle.
- stall  input  1  hazard unit: hold PC and IF/ID (load-use).
- id_branch_taken  input  1  BNE in ID resolved taken.
- id_jump  input  1  J in ID.
- if_id_instr  output  32  registered instruction for ID.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- OP  output  6  if_id_instr[31:26], to control unit.
- func  output  6  if_id_instr[5:0], to control unit.
- pc  output  32  current PC (debug/trace).

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC; if_id_instr=NOP_WORD; if_id_pc_plus4=0; if_id_valid=0. Outputs hold these values while rst_n is low. First fetch occurs on the first rising edge after deassertion.
- Reset mid-operation: all state is discarded immediately; no partial redirect survives.
- imem_addr = pc, combinational. pc[1:0] is always 00.
- Target arithmetic uses the IF/ID fields, i.e. the instruction currently in ID:
  - branch_target = if_id_pc_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00}, with imm = if_id_instr[15:0]; 32-bit, wraps modulo 2^32.
  - jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- Per-edge priority (first match wins):
  - (1) stall=1: pc, if_id_* all hold. id_branch_taken and id_jump are ignored, because the held ID instruction re-resolves next cycle.
  - (2) id_jump=1: pc<=jump_target; IF/ID<=bubble (instr=NOP_WORD, valid=0, pc_plus4 holds).
  - (3) id_branch_taken=1: pc<=branch_target; IF/ID<=bubble.
  - (4) otherwise: pc<=pc+4; if_id_instr<=imem_rdata; if_id_pc_plus4<=pc+4; if_id_valid<=1.
- id_jump and id_branch_taken both high: jump wins (decoder must not produce this; no assertion).
- Redirect/branch inputs are ignored when if_id_valid=0: a bubble never redirects.
- Latency: instruction at address A appears on if_id_instr one edge after pc==A with no stall. Taken-branch penalty = 1 bubble.
- PC wrap: pc+4 at 32'hFFFF_FFFC gives 32'h0000_0000; no error.
- Stall of any length is lossless: the fetched word is re-read from the unchanged imem_addr on release.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0]. Both are reset to 0 by rst_n and wrap at 2^32.
  - perf_fetched increments on every priority-(4) edge.
  - perf_bubbles increments on every priority-(2)/(3) edge.
  - Stall edges count in neither.
- Undefined: ports and counters absent; the remaining behaviour is identical.

Test Plan:
- Reset then free-run with imem[0]=32'h8C01_0004, imem[4]=32'h0022_1820 -> first edge: if_id_instr=8C010004, pc_plus4=4, valid=1, OP=6'h23. Next edge: OP=0, func=6'h20, pc=8.
- Stall held 3 cycles at pc=8 -> pc, if_id_instr, if_id_pc_plus4 unchanged all 3 edges; the word at 8 is latched on the first edge after release.
- BNE in ID at pc_plus4=0x14, imm=16'hFFFD, id_branch_taken=1 -> pc=0x08, if_id_valid=0, if_id_instr=0. Next edge fetches 0x08.
- J in ID with pc_plus4=0x4000_0010, index=26'h0000040 -> pc=0x4000_0100, one bubble.
- stall=1 together with id_jump=1 -> no redirect that edge. Stall released with id_jump still 1 -> redirect occurs.
- rst_n pulsed low mid-cycle during redirect -> pc=RESET_PC and valid=0 immediately, before the next clock edge. With FETCH_PERF_CNT_EN defined, both counters read 0.
